// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback driver: captures retiring instructions,
// extracts/extends load data and drives the register file write port plus a forwarding copy.
module mem_wb_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_flush,
    input  logic        in_reg_write,
    input  logic        in_mem_to_reg,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_data,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        reg_write,
    output logic [4:0]  write_register,
    output logic [31:0] write_data,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic        misalign_err,
    output logic [31:0] retire_count
);

    // Little-endian sub-word selection with sign or zero extension.
    function automatic logic [31:0] load_extract(
        input logic [31:0] data,
        input logic [1:0]  lane,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        byte_v = 8'd0;
        half_v = 16'd0;
        res_v  = data;
        case (lane)
            2'd0:    byte_v = data[7:0];
            2'd1:    byte_v = data[15:8];
            2'd2:    byte_v = data[23:16];
            2'd3:    byte_v = data[31:24];
            default: byte_v = data[7:0];
        endcase
        if (lane[1]) begin
            half_v = data[31:16];
        end else begin
            half_v = data[15:0];
        end
        case (size)
            2'd0: begin
                if (uns) begin
                    res_v = {24'd0, byte_v};
                end else begin
                    res_v = {{24{byte_v[7]}}, byte_v};
                end
            end
            2'd1: begin
                if (uns) begin
                    res_v = {16'd0, half_v};
                end else begin
                    res_v = {{16{half_v[15]}}, half_v};
                end
            end
            default: res_v = data;
        endcase
        return res_v;
    endfunction

    // Alignment rule: bytes never fault, halfwords need bit 0 clear, words (and reserved) need both low bits clear.
    function automatic logic is_misaligned(
        input logic [1:0] lane,
        input logic [1:0] size
    );
        logic mis_v;
        case (size)
            2'd0:    mis_v = 1'b0;
            2'd1:    mis_v = lane[0];
            default: mis_v = (lane != 2'd0);
        endcase
        return mis_v;
    endfunction

    logic        valid_s;
    logic        mis_s;
    logic [31:0] load_val_s;
    logic [31:0] wdata_next_s;
    logic        we_next_s;
    logic        merr_next_s;
    logic        retire_next_s;

    logic        reg_write_r;
    logic [4:0]  write_register_r;
    logic [31:0] write_data_r;
    logic        misalign_err_r;
    logic        retire_pend_r;
    logic [31:0] retire_count_r;

    // Writeback decision for the instruction leaving MEM; flush squashes it into a bubble.
    always_comb begin
        valid_s       = 1'b0;
        mis_s         = 1'b0;
        load_val_s    = 32'd0;
        wdata_next_s  = 32'd0;
        we_next_s     = 1'b0;
        merr_next_s   = 1'b0;
        retire_next_s = 1'b0;

        valid_s    = in_valid & ~in_flush;
        load_val_s = load_extract(in_mem_data, in_alu_result[1:0], in_size, in_unsigned);
        if (in_mem_to_reg) begin
            mis_s        = is_misaligned(in_alu_result[1:0], in_size);
            wdata_next_s = load_val_s;
        end else begin
            mis_s        = 1'b0;
            wdata_next_s = in_alu_result;
        end
        we_next_s     = valid_s & in_reg_write & (in_dest != 5'd0) & ~mis_s;
        merr_next_s   = valid_s & in_mem_to_reg & mis_s;
        retire_next_s = valid_s & ~mis_s;
    end

    // WB stage register: the write strobe, address and data are held here for the RF cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r      <= 1'b0;
            write_register_r <= 5'd0;
            write_data_r     <= 32'd0;
            misalign_err_r   <= 1'b0;
            retire_pend_r    <= 1'b0;
        end else begin
            reg_write_r      <= we_next_s;
            write_register_r <= in_dest;
            write_data_r     <= wdata_next_s;
            misalign_err_r   <= merr_next_s;
            retire_pend_r    <= retire_next_s;
        end
    end

    // Retire counter advances on the edge where a good instruction leaves WB; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count_r <= 32'd0;
        end else if (retire_pend_r) begin
            retire_count_r <= retire_count_r + 32'd1;
        end else begin
            retire_count_r <= retire_count_r;
        end
    end

    assign reg_write      = reg_write_r;
    assign write_register = write_register_r;
    assign write_data     = write_data_r;
    assign fwd_valid      = reg_write_r;
    assign fwd_reg        = write_register_r;
    assign fwd_data       = write_data_r;
    assign misalign_err   = misalign_err_r;
    assign retire_count   = retire_count_r;

endmodule
